// File: rtl/wb_trace_buffer_pkg.sv
// Shared types for the write-back trace buffer: entry layout, FSM states, signature step.
// Optional macro TRACE_PC_EN adds a per-entry PC field.
package wb_trace_pkg;

    localparam int          TRACE_DATA_W = 16;
    localparam int          TRACE_REG_AW = 4;
    localparam logic [15:0] SIG_INIT     = 16'h0000;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HALTED = 2'd1,
        DONE   = 2'd2
    } state_t;

    // 'reg' is a keyword, so the destination register field is called dst.
    typedef struct packed {
        logic [TRACE_REG_AW-1:0] dst;
        logic [TRACE_DATA_W-1:0] data;
`ifdef TRACE_PC_EN
        logic [15:0]             pc;
`endif
        logic [2:0]              flags;
    } trace_entry_t;

    function automatic logic [15:0] sig_next(input logic [15:0] s,
                                             input logic [15:0] data,
                                             input logic [15:0] dst);
        return {s[14:0], s[15]} ^ data ^ dst;
    endfunction

endpackage

// File: rtl/wb_trace_buffer_if.sv
// Write-back capture and trace drain bus between the WB stage, the buffer and the monitor.
interface wb_trace_buffer_if #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 4
);
    logic              wb_en;
    logic [REG_AW-1:0] wb_reg;
    logic [DATA_W-1:0] wb_data;
    logic [15:0]       wb_pc;
    logic [2:0]        wb_flags;
    logic              halt;

    // Drain side: an entry transfers on any clock edge where tr_valid && tr_ready.
    // tr_valid never depends on tr_ready, and tr_* stay stable while tr_valid && !tr_ready.
    logic              tr_valid;
    logic              tr_ready;
    logic [REG_AW-1:0] tr_reg;
    logic [DATA_W-1:0] tr_data;
    logic [15:0]       tr_pc;
    logic [2:0]        tr_flags;

    modport master (
        output wb_en, wb_reg, wb_data, wb_pc, wb_flags, halt, tr_ready,
        input  tr_valid, tr_reg, tr_data, tr_pc, tr_flags
    );

    modport slave (
        input  wb_en, wb_reg, wb_data, wb_pc, wb_flags, halt, tr_ready,
        output tr_valid, tr_reg, tr_data, tr_pc, tr_flags
    );
endinterface

// File: rtl/wb_trace_buffer_fifo.sv
// Synchronous FIFO of trace entries with a registered head: a pushed entry appears
// on head_o the cycle after the push edge, and head_o holds its last value when empty.
module trace_fifo
    import wb_trace_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  trace_entry_t push_data_i,
    input  logic         pop_i,
    output trace_entry_t head_o,
    output logic         full_o,
    output logic         empty_o,
    output logic [CW-1:0] count_o
);
    trace_entry_t  mem_q [DEPTH];
    trace_entry_t  head_q, head_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign head_o  = head_q;
    assign count_o = count_q;

    always_comb begin
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
        // The new head is the word being written when it lands in the slot the read pointer moves to.
        head_d = head_q;
        if (count_d != '0) begin
            head_d = (do_push && (wr_ptr_q == rd_ptr_d)) ? push_data_i : mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/wb_trace_buffer.sv
// Write-back trace buffer: R0 filter, signature, overflow count and halt/drain FSM around trace_fifo.
// Define TRACE_PC_EN to store and return the PC of each retired write-back.
module wb_trace_buffer
    import wb_trace_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int DATA_W = TRACE_DATA_W,
    parameter int REG_AW = TRACE_REG_AW,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic                clk,
    input  logic                rst,
    wb_trace_buffer_if.slave    bus,
    output logic [CW-1:0]       count,
    output logic [15:0]         ovf_cnt,
    output logic [15:0]         sig,
    output logic                done,
    output state_t              state_o
);
    state_t       state_q;
    logic         done_q;
    logic [15:0]  sig_q, sig_d;
    logic [15:0]  ovf_q, ovf_d;
    trace_entry_t wr_entry, head;
    logic         push_try, pop, fifo_full, fifo_empty;

    assign push_try = (state_q == RUN) && bus.wb_en && (bus.wb_reg != '0);
    assign pop      = !fifo_empty && bus.tr_ready;

    always_comb begin
        wr_entry       = '0;
        wr_entry.dst   = bus.wb_reg;
        wr_entry.data  = bus.wb_data;
`ifdef TRACE_PC_EN
        wr_entry.pc    = bus.wb_pc;
`endif
        wr_entry.flags = bus.wb_flags;
    end

    trace_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push_try),
        .push_data_i (wr_entry),
        .pop_i       (bus.tr_ready),
        .head_o      (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (count)
    );

    // Dropped pushes still fold into the signature so it reflects everything retired.
    always_comb begin
        sig_d = sig_q;
        ovf_d = ovf_q;
        if (push_try) begin
            sig_d = sig_next(sig_q, 16'(bus.wb_data), 16'(bus.wb_reg));
            if (fifo_full && !pop && (ovf_q != 16'hFFFF)) begin
                ovf_d = ovf_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sig_q <= SIG_INIT;
            ovf_q <= '0;
        end else begin
            sig_q <= sig_d;
            ovf_q <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= RUN;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (bus.halt) state_q <= HALTED;
                end
                HALTED: begin
                    if ((count == '0) || ((count == CW'(1)) && pop)) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    done_q <= 1'b1;
                end
                default: begin
                    state_q <= RUN;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.tr_valid = !fifo_empty;
    assign bus.tr_reg   = head.dst;
    assign bus.tr_data  = head.data;
    assign bus.tr_flags = head.flags;
`ifdef TRACE_PC_EN
    assign bus.tr_pc    = head.pc;
`else
    assign bus.tr_pc    = 16'h0000;
`endif

    assign ovf_cnt = ovf_q;
    assign sig     = sig_q;
    assign done    = done_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Directed bench for wb_trace_buffer with an expected-entry queue and hand-computed checkpoints.
module tb_wb_trace_buffer;
    import wb_trace_pkg::*;

    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    wb_trace_buffer_if #(.DATA_W(16), .REG_AW(4)) bus ();

    logic [4:0]  count;
    logic [15:0] ovf_cnt;
    logic [15:0] sig;
    logic        done;
    state_t      state_o;

    wb_trace_buffer #(.DEPTH(DEPTH), .DATA_W(16), .REG_AW(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .count   (count),
        .ovf_cnt (ovf_cnt),
        .sig     (sig),
        .done    (done),
        .state_o (state_o)
    );

    // Expected entries, packed as {reg[38:35], data[34:19], pc[18:3], flags[2:0]}
    logic [38:0] exp_q[$];
    logic [15:0] sig_m;
    logic [15:0] ovf_m;
    state_t      state_m;
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wb(input logic [3:0] r, input logic [15:0] d, input logic [15:0] pc,
                      input logic [2:0] f);
        bus.wb_en    = 1'b1;
        bus.wb_reg   = r;
        bus.wb_data  = d;
        bus.wb_pc    = pc;
        bus.wb_flags = f;
    endtask

    task automatic wb_idle();
        bus.wb_en = 1'b0;
    endtask

    task automatic model_reset();
        exp_q.delete();
        sig_m   = 16'h0000;
        ovf_m   = 16'h0000;
        state_m = RUN;
    endtask

    // Advance one clock (negedge to negedge) and update the expected state for that edge.
    task automatic tick();
        logic        pop, push, full;
        logic [15:0] pc_m;
        full = (exp_q.size() == DEPTH);
        pop  = (exp_q.size() != 0) && bus.tr_ready;
        push = (state_m == RUN) && bus.wb_en && (bus.wb_reg != 4'd0);
`ifdef TRACE_PC_EN
        pc_m = bus.wb_pc;
`else
        pc_m = 16'h0000;
`endif
        if (push) begin
            sig_m = {sig_m[14:0], sig_m[15]} ^ bus.wb_data ^ {12'h000, bus.wb_reg};
            if (full && !pop && ovf_m != 16'hFFFF) ovf_m = ovf_m + 16'd1;
        end
        case (state_m)
            RUN:     if (bus.halt) state_m = HALTED;
            HALTED:  if (exp_q.size() == 0 || (exp_q.size() == 1 && pop)) state_m = DONE;
            default: ;
        endcase
        if (pop) void'(exp_q.pop_front());
        if (push && (!full || pop)) exp_q.push_back({bus.wb_reg, bus.wb_data, pc_m, bus.wb_flags});
        @(negedge clk);
    endtask

    task automatic check_head(input string tag);
        logic [38:0] e;
        check({tag, ".valid"}, bus.tr_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
            e = exp_q[0];
            check({tag, ".reg"},   bus.tr_reg,   e[38:35]);
            check({tag, ".data"},  bus.tr_data,  e[34:19]);
            check({tag, ".pc"},    bus.tr_pc,    e[18:3]);
            check({tag, ".flags"}, bus.tr_flags, e[2:0]);
        end
    endtask

    task automatic check_status(input string tag);
        check({tag, ".count"}, count, exp_q.size());
        check({tag, ".ovf"},   ovf_cnt, ovf_m);
        check({tag, ".sig"},   sig, sig_m);
        check({tag, ".done"},  done, state_m == DONE);
        check({tag, ".state"}, state_o, state_m);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        bus.wb_en = 1'b0;
        bus.halt  = 1'b0;
        @(negedge clk);
        model_reset();
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [3:0]  snap_reg;
        logic [15:0] snap_data;
        logic        stall;

        bus.wb_en = 1'b0; bus.wb_reg = '0; bus.wb_data = '0; bus.wb_pc = '0;
        bus.wb_flags = '0; bus.halt = 1'b0; bus.tr_ready = 1'b0;
        @(negedge clk);
        do_reset();

        // Reset state
        check("rst.count", count, 0);
        check("rst.valid", bus.tr_valid, 0);
        check("rst.reg",   bus.tr_reg, 0);
        check("rst.data",  bus.tr_data, 0);
        check("rst.sig",   sig, 16'h0000);
        check("rst.ovf",   ovf_cnt, 0);
        check("rst.done",  done, 0);
        check("rst.state", state_o, RUN);

        // Two back-to-back writes drained in order
        bus.tr_ready = 1'b1;
        wb(4'd1, 16'h0001, 16'h0100, 3'b001);
        tick();
        check_head("t1a");
        check("t1.sig0", sig, 16'h0000);
        wb(4'd2, 16'h0010, 16'h0102, 3'b000);
        tick();
        check_head("t1b");
        check("t1.reg2", bus.tr_reg, 4'd2);
        check("t1.sig1", sig, 16'h0012);
        wb_idle();
        tick();
        check("t1.empty", bus.tr_valid, 0);
        check("t1.hold",  bus.tr_data, 16'h0010);
        check_status("t1");

        // R0 writes are invisible
        wb(4'd0, 16'hFFFF, 16'h0104, 3'b111);
        tick();
        wb_idle();
        check("t2.count", count, 0);
        check("t2.sig",   sig, 16'h0012);
        check("t2.valid", bus.tr_valid, 0);

        // Overflow: DEPTH+3 pushes without draining
        bus.tr_ready = 1'b0;
        for (int i = 0; i < DEPTH + 3; i++) begin
            wb(4'((i % 15) + 1), 16'(i * 16'h0111), 16'(16'h0200 + i), 3'(i));
            tick();
        end
        check("t3.count", count, DEPTH);
        check("t3.ovf",   ovf_cnt, 3);
        check_head("t3.head");
        check_status("t3");
        // Push with a simultaneous pop while full is accepted
        bus.tr_ready = 1'b1;
        wb(4'hF, 16'hBEEF, 16'h0300, 3'b101);
        tick();
        wb_idle();
        check("t3.count_pp", count, DEPTH);
        check("t3.ovf_pp",   ovf_cnt, 3);
        check_head("t3.pp");
        for (int k = 0; k < DEPTH + 4; k++) begin
            check_head("t3.drain");
            tick();
        end
        check("t3.drained", count, 0);
        check_status("t3.end");

        // Halt with a write in the same cycle; later writes ignored
        bus.tr_ready = 1'b0;
        wb(4'd3, 16'h0033, 16'h0400, 3'b010);
        tick();
        wb(4'd14, 16'h000B, 16'h0402, 3'b010);
        bus.halt = 1'b1;
        tick();
        bus.halt = 1'b0;
        wb(4'd5, 16'h1234, 16'h0404, 3'b000);
        tick();
        tick();
        wb_idle();
        check("t4.count", count, 2);
        check("t4.state", state_o, HALTED);
        check_status("t4");
        check_head("t4.h0");
        bus.tr_ready = 1'b1;
        tick();
        check_head("t4.h1");
        check("t4.r14",  bus.tr_reg, 4'd14);
        check("t4.d14",  bus.tr_data, 16'h000B);
        check("t4.done0", done, 0);
        tick();
        check("t4.done1", done, 1);
        check("t4.stD",   state_o, DONE);
        check("t4.cnt0",  count, 0);
        wb(4'd6, 16'h6666, 16'h0406, 3'b001);
        bus.halt = 1'b1;
        tick();
        bus.halt = 1'b0;
        wb_idle();
        check("t4.stay_done", done, 1);
        check("t4.stay_cnt",  count, 0);
        check_status("t4.end");

        // Back-pressure with tr_ready toggling
        do_reset();
        for (int i = 0; i < 8; i++) begin
            bus.tr_ready = i[0];
            wb(4'(i + 1), 16'(16'h00A0 + i), 16'(16'h0500 + i), 3'(i));
            stall     = bus.tr_valid && !bus.tr_ready;
            snap_reg  = bus.tr_reg;
            snap_data = bus.tr_data;
            tick();
            if (stall) begin
                check("t5.stable_reg",  bus.tr_reg, snap_reg);
                check("t5.stable_data", bus.tr_data, snap_data);
            end
            check_head("t5.bp");
        end
        wb_idle();
        bus.tr_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            check_head("t5.drain");
            tick();
        end
        check_status("t5.end");

        // Reset mid-drain while halted with 5 entries queued
        bus.tr_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wb(4'(7 + i), 16'(16'h0C00 + i), 16'(16'h0600 + i), 3'b011);
            tick();
        end
        wb_idle();
        bus.halt = 1'b1;
        tick();
        bus.halt = 1'b0;
        check("t6.count5", count, 5);
        check("t6.halted", state_o, HALTED);
        do_reset();
        check("t6.count", count, 0);
        check("t6.valid", bus.tr_valid, 0);
        check("t6.data",  bus.tr_data, 0);
        check("t6.done",  done, 0);
        check("t6.state", state_o, RUN);
        check("t6.sig",   sig, 16'h0000);
        wb(4'd1, 16'h5555, 16'h0700, 3'b100);
        tick();
        wb_idle();
        check_head("t6.after");
        check("t6.sig1", sig, 16'h5554);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
